// File: rtl/spi_weight_master.sv
// SPI master (mode 0) that snapshots the beamformer phase weights on START and
// shifts them out MSB first as one 160-bit SS-framed transfer.
module spi_weight_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic [39:0] W_COS_1,
    input  logic [39:0] W_SIN_1,
    input  logic [39:0] W_COS_2,
    input  logic [39:0] W_SIN_2,
    output logic        BUSY,
    output logic        DONE,
    output logic        SCLK,
    output logic        SS,
    output logic        MOSI
);

    localparam int unsigned FRAME_BITS = 160;
    localparam int unsigned MAX_AB     = (CLK_DIV > SETUP_CYC) ? CLK_DIV : SETUP_CYC;
    localparam int unsigned MAX_CYC    = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int unsigned CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t                      state;
    logic [CNT_W-1:0]            phase_cnt;
    logic [7:0]                  bit_cnt;
    // Bits still to be sent after the one currently on MOSI.
    logic [FRAME_BITS-2:0]       shreg;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            SCLK      <= 1'b0;
            SS        <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        shreg     <= {W_COS_1[38:0], W_SIN_1, W_COS_2, W_SIN_2};
                        MOSI      <= W_COS_1[39];
                        SS        <= 1'b0;
                        BUSY      <= 1'b1;
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_cnt == CNT_W'(SETUP_CYC - 1)) begin
                        phase_cnt <= '0;
                        state     <= LOW;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (phase_cnt == CNT_W'(CLK_DIV - 1)) begin
                        phase_cnt <= '0;
                        SCLK      <= 1'b1;
                        state     <= HIGH;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_cnt == CNT_W'(CLK_DIV - 1)) begin
                        phase_cnt <= '0;
                        SCLK      <= 1'b0;
                        bit_cnt   <= bit_cnt + 1'b1;
                        // Next bit changes together with the SCLK fall.
                        if (bit_cnt == 8'(FRAME_BITS - 1)) begin
                            MOSI  <= 1'b0;
                            state <= HOLD;
                        end else begin
                            MOSI  <= shreg[FRAME_BITS-2];
                            shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
                            state <= LOW;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (phase_cnt == CNT_W'(HOLD_CYC - 1)) begin
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        SS        <= 1'b1;
                        DONE      <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_weight_master.sv
// Bench for spi_weight_master: an SPI slave model captures each frame and compares it
// with the weights presented at START; default and fastest-divider instances are exercised.
module tb_spi_weight_master;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic        sel   = 1'b0;
    logic [39:0] wc1 = '0, ws1 = '0, wc2 = '0, ws2 = '0;

    logic busy0, done0, sclk0, ss0, mosi0;
    logic busy1, done1, sclk1, ss1, mosi1;
    logic m_busy, m_done, m_sclk, m_ss, m_mosi;

    int n_chk  = 0;
    int n_fail = 0;

    logic [159:0] cap  = '0;
    int           capn = 0;

    always #5 CLOCK = ~CLOCK;

    spi_weight_master dut0 (
        .CLOCK(CLOCK), .RESET(RESET), .START(start & ~sel),
        .W_COS_1(wc1), .W_SIN_1(ws1), .W_COS_2(wc2), .W_SIN_2(ws2),
        .BUSY(busy0), .DONE(done0), .SCLK(sclk0), .SS(ss0), .MOSI(mosi0)
    );

    spi_weight_master #(.CLK_DIV(1), .SETUP_CYC(1), .HOLD_CYC(1)) dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .START(start & sel),
        .W_COS_1(wc1), .W_SIN_1(ws1), .W_COS_2(wc2), .W_SIN_2(ws2),
        .BUSY(busy1), .DONE(done1), .SCLK(sclk1), .SS(ss1), .MOSI(mosi1)
    );

    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_ss   = sel ? ss1   : ss0;
    assign m_mosi = sel ? mosi1 : mosi0;

    // Slave model: new frame on SS fall, sample MOSI on each SCLK rise while selected.
    always @(negedge m_ss) begin
        cap  = '0;
        capn = 0;
    end
    always @(posedge m_sclk) begin
        if (!m_ss) begin
            cap  = {cap[158:0], m_mosi};
            capn = capn + 1;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] rnd160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_idle(input string tag);
        chk1({tag, "_ss"},   m_ss,   1'b1);
        chk1({tag, "_sclk"}, m_sclk, 1'b0);
        chk1({tag, "_mosi"}, m_mosi, 1'b0);
        chk1({tag, "_busy"}, m_busy, 1'b0);
        chk1({tag, "_done"}, m_done, 1'b0);
    endtask

    // Called at a falling edge while the selected DUT is idle (or in its DONE cycle).
    // p1/p2: cycles at which a spurious START is pulsed; scramble: change weights after START.
    task automatic run_frame(input logic [159:0] w, input int p1, input int p2,
                             input bit scramble);
        int n;
        int gaps;
        int exp_cyc;
        logic ss_before;
        exp_cyc = sel ? (1 + 1 + 320 * 1 + 1) : (1 + 2 + 320 * 4 + 2);
        {wc1, ws1, wc2, ws2} = w;
        start = 1'b1;
        @(posedge CLOCK);
        n = 1;
        @(negedge CLOCK);
        start = 1'b0;
        if (scramble) {wc1, ws1, wc2, ws2} = ~w ^ rnd160();
        chk1("ss_fall",    m_ss,   1'b0);
        chk1("busy_rise",  m_busy, 1'b1);
        chk1("mosi_first", m_mosi, w[159]);
        gaps      = 0;
        ss_before = 1'b1;
        while (!m_done && n < 3000) begin
            start     = (n == p1 || n == p2);
            ss_before = m_ss;
            @(posedge CLOCK);
            n++;
            @(negedge CLOCK);
            if (!m_done && !m_busy) gaps++;
        end
        start = 1'b0;
        chk1("done_seen",    m_done,    1'b1);
        chkn("done_cycle",   n,         exp_cyc);
        chkn("busy_gaps",    gaps,      0);
        chk1("ss_low_hold",  ss_before, 1'b0);
        chk1("ss_high_done", m_ss,      1'b1);
        chk1("busy_fall",    m_busy,    1'b0);
        chkn("bit_count",    capn,      160);
        chkw("frame",        cap,       w);
    endtask

    initial begin
        logic [159:0] w;
        int ss_low;
        int dn;

        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        chk_idle("rst0");
        sel = 1'b1;
        #1;
        chk_idle("rst1");
        sel = 1'b0;
        RESET = 1'b0;
        @(negedge CLOCK);

        // Single pattern in W_COS_1 only.
        w = {40'h84_2108_4210, 120'b0};
        run_frame(w, -1, -1, 1'b0);
        chkw("slave_w_cos_1", 160'(cap[159:120]), 160'(40'h84_2108_4210));
        chkw("slave_others",  160'(cap[119:0]),   160'(0));
        @(negedge CLOCK);
        chk_idle("after_t1");

        // Twenty random frames, each START issued in the previous DONE cycle.
        for (int i = 0; i < 20; i++) run_frame(rnd160(), -1, -1, 1'b0);
        @(negedge CLOCK);
        chk_idle("after_b2b");

        // Spurious STARTs during a frame are dropped, nothing queued afterwards.
        run_frame(rnd160(), 50, 700, 1'b0);
        ss_low = 0;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK);
            if (!m_ss) ss_low++;
            if (m_done) dn++;
        end
        chkn("no_queued_frame", ss_low, 0);
        chkn("single_done",     dn,     0);

        // Reset mid-frame at cycle 600.
        {wc1, ws1, wc2, ws2} = rnd160();
        start = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        start = 1'b0;
        for (int n = 1; n < 600; n++) begin
            @(posedge CLOCK);
            @(negedge CLOCK);
        end
        chk1("pre_reset_busy", m_busy, 1'b1);
        RESET = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        chk_idle("mid_reset");
        RESET = 1'b0;
        dn = 0;
        ss_low = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLOCK);
            if (m_done) dn++;
            if (!m_ss) ss_low++;
        end
        chkn("no_partial_done", dn,     0);
        chkn("stay_idle",       ss_low, 0);
        run_frame(rnd160(), -1, -1, 1'b0);
        @(negedge CLOCK);

        // Weights changing right after START must not reach the wire.
        run_frame(rnd160(), -1, -1, 1'b1);
        @(negedge CLOCK);

        // Fastest configuration: SCLK toggles every cycle.
        sel = 1'b1;
        @(negedge CLOCK);
        run_frame(rnd160(), -1, -1, 1'b0);
        run_frame(rnd160(), -1, -1, 1'b1);
        @(negedge CLOCK);
        chk_idle("fast_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
